llc_req_splitter: RTL and testbench

LLC_REQ_SPLITTER -- requirements
Module: llc_req_splitter

---
 rtl/llm_params.sv | 40 ++++
 rtl/llc_line_count.sv | 25 ++
 rtl/llc_req_splitter.sv | 183 ++++++++++++++++++
 tb/tb_llc_req_splitter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llm_params.sv
// Shared LLC geometry, CHI field widths and the lookup bundle used by the request splitter.
// LLC_SPLIT_PREFETCH_EN adds the PREF state to split_state_e.
package llm_params;

  localparam int ADDR_WIDTH         = 64;
  localparam int LLC_CACHELINE_SIZE = 64;
  localparam int LLC_NUM_SETS       = 4096;
  localparam int OFFSET_WIDTH       = $clog2(LLC_CACHELINE_SIZE);
  localparam int SET_INDEX_WIDTH    = $clog2(LLC_NUM_SETS);
  localparam int LINE_WIDTH         = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int TAG_WIDTH          = LINE_WIDTH - SET_INDEX_WIDTH;
  localparam int CHI_TXN_ID_WIDTH   = 16;
  localparam int CHI_PRIO_WIDTH     = 3;
  localparam int SIZE_WIDTH         = 9;
  localparam int BEAT_WIDTH         = 3;
  localparam int NLINES_WIDTH       = 3;
  localparam int CNT_WIDTH          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPLIT = 2'd1
`ifdef LLC_SPLIT_PREFETCH_EN
    ,
    PREF  = 2'd2
`endif
  } split_state_e;

  // One lookup as presented to the tag-lookup stage; line = {tag, set}.
  typedef struct packed {
    logic [LINE_WIDTH-1:0]       line;
    logic [OFFSET_WIDTH-1:0]     offset;
    logic [CHI_TXN_ID_WIDTH-1:0] txn_id;
    logic [CHI_PRIO_WIDTH-1:0]   prio;
    logic                        write;
    logic [BEAT_WIDTH-1:0]       beat;
    logic                        last;
    logic                        prefetch;
  } lk_req_t;

endpackage

// File: rtl/llc_line_count.sv
// Combinational line count and size legality for an incoming request.
// Only the low address bits matter: the true count is at most 5, so arithmetic mod 8 is exact.
module llc_line_count
  import llm_params::*;
#(
  parameter int MAX_ACCESS_SIZE = 256
) (
  input  logic [OFFSET_WIDTH+NLINES_WIDTH-1:0] addr_lo,
  input  logic [SIZE_WIDTH-1:0]                size,
  output logic [NLINES_WIDTH-1:0]              nlines,
  output logic                                 legal
);

  localparam int LW = OFFSET_WIDTH + NLINES_WIDTH;

  logic [LW-1:0] end_lo_s;

  // Last byte address (low bits), then line-index difference.
  always_comb begin
    end_lo_s = addr_lo + LW'(size) - LW'(1);
    nlines   = end_lo_s[LW-1:OFFSET_WIDTH] - addr_lo[LW-1:OFFSET_WIDTH] + NLINES_WIDTH'(1);
    legal    = (size != SIZE_WIDTH'(0)) && (32'(size) <= MAX_ACCESS_SIZE);
  end

endmodule

// File: rtl/llc_req_splitter.sv
// Splits byte-addressed LLC requests into per-line tag lookups (optional read prefetch).
// Define LLC_SPLIT_PREFETCH_EN to enable the PREF state.
module llc_req_splitter
  import llm_params::*;
#(
  parameter int CACHELINE_SIZE  = LLC_CACHELINE_SIZE,
  parameter int MAX_ACCESS_SIZE = 256,
  parameter int NUM_SETS        = LLC_NUM_SETS,
  parameter int PREFETCH_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic [SIZE_WIDTH-1:0]       req_size,
  input  logic [CHI_TXN_ID_WIDTH-1:0] req_txn_id,
  input  logic [CHI_PRIO_WIDTH-1:0]   req_prio,
  input  logic                        req_write,
  output logic                        lk_valid,
  input  logic                        lk_ready,
  output logic [TAG_WIDTH-1:0]        lk_tag,
  output logic [SET_INDEX_WIDTH-1:0]  lk_set,
  output logic [OFFSET_WIDTH-1:0]     lk_offset,
  output logic [CHI_TXN_ID_WIDTH-1:0] lk_txn_id,
  output logic [CHI_PRIO_WIDTH-1:0]   lk_prio,
  output logic                        lk_write,
  output logic [BEAT_WIDTH-1:0]       lk_beat,
  output logic                        lk_last,
  output logic                        lk_prefetch,
  output logic                        err_size,
  output logic                        busy
);

  // Geometry lives in llm_params; the parameters must agree with it.
  if ((CACHELINE_SIZE != (1 << OFFSET_WIDTH)) || (NUM_SETS != (1 << SET_INDEX_WIDTH)) ||
      (PREFETCH_DEPTH < 0) || (PREFETCH_DEPTH >= (1 << CNT_WIDTH))) begin : g_param_check
    $error("llc_req_splitter: parameters inconsistent with llm_params");
  end

  split_state_e             state_r, state_nx_s;
  lk_req_t                  lk_r, lk_nx_s;
  logic                     lk_valid_r, lk_valid_nx_s;
  logic [NLINES_WIDTH-1:0]  dem_left_r, dem_left_nx_s;
  logic [CNT_WIDTH-1:0]     pref_left_r, pref_left_nx_s, pref_init_s;
  logic                     err_r, err_nx_s;
  logic                     busy_r, req_ready_r;
  logic [NLINES_WIDTH-1:0]  nlines_s;
  logic                     legal_s, accept_s;

  llc_line_count #(.MAX_ACCESS_SIZE(MAX_ACCESS_SIZE)) u_line_count (
    .addr_lo (req_addr[OFFSET_WIDTH+NLINES_WIDTH-1:0]),
    .size    (req_size),
    .nlines  (nlines_s),
    .legal   (legal_s)
  );

  assign accept_s = req_valid && req_ready_r;

`ifdef LLC_SPLIT_PREFETCH_EN
  assign pref_init_s = req_write ? CNT_WIDTH'(0) : CNT_WIDTH'(PREFETCH_DEPTH);
`else
  assign pref_init_s = CNT_WIDTH'(0);
`endif

  // Next-state and next-lookup computation.
  always_comb begin
    state_nx_s     = state_r;
    lk_nx_s        = lk_r;
    lk_valid_nx_s  = lk_valid_r;
    dem_left_nx_s  = dem_left_r;
    pref_left_nx_s = pref_left_r;
    err_nx_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && legal_s) begin
          state_nx_s       = SPLIT;
          lk_valid_nx_s    = 1'b1;
          lk_nx_s.line     = req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
          lk_nx_s.offset   = req_addr[OFFSET_WIDTH-1:0];
          lk_nx_s.txn_id   = req_txn_id;
          lk_nx_s.prio     = req_prio;
          lk_nx_s.write    = req_write;
          lk_nx_s.beat     = BEAT_WIDTH'(0);
          lk_nx_s.prefetch = 1'b0;
          lk_nx_s.last     = (nlines_s == NLINES_WIDTH'(1)) && (pref_init_s == CNT_WIDTH'(0));
          dem_left_nx_s    = nlines_s - NLINES_WIDTH'(1);
          pref_left_nx_s   = pref_init_s;
        end else if (accept_s) begin
          err_nx_s = 1'b1;
        end else begin
          lk_valid_nx_s = 1'b0;
        end
      end
      SPLIT: begin
        if (lk_valid_r && lk_ready && (dem_left_r != NLINES_WIDTH'(0))) begin
          lk_nx_s.line   = lk_r.line + LINE_WIDTH'(1);
          lk_nx_s.offset = OFFSET_WIDTH'(0);
          lk_nx_s.beat   = lk_r.beat + BEAT_WIDTH'(1);
          lk_nx_s.last   = (dem_left_r == NLINES_WIDTH'(1)) && (pref_left_r == CNT_WIDTH'(0));
          dem_left_nx_s  = dem_left_r - NLINES_WIDTH'(1);
`ifdef LLC_SPLIT_PREFETCH_EN
        end else if (lk_valid_r && lk_ready && (pref_left_r != CNT_WIDTH'(0))) begin
          state_nx_s       = PREF;
          lk_nx_s.line     = lk_r.line + LINE_WIDTH'(1);
          lk_nx_s.offset   = OFFSET_WIDTH'(0);
          lk_nx_s.beat     = lk_r.beat + BEAT_WIDTH'(1);
          lk_nx_s.prio     = CHI_PRIO_WIDTH'(0);
          lk_nx_s.prefetch = 1'b1;
          lk_nx_s.last     = (pref_left_r == CNT_WIDTH'(1));
          pref_left_nx_s   = pref_left_r - CNT_WIDTH'(1);
`endif
        end else if (lk_valid_r && lk_ready) begin
          state_nx_s       = IDLE;
          lk_valid_nx_s    = 1'b0;
          lk_nx_s.last     = 1'b0;
          lk_nx_s.prefetch = 1'b0;
        end else begin
          lk_valid_nx_s = lk_valid_r;
        end
      end
`ifdef LLC_SPLIT_PREFETCH_EN
      PREF: begin
        if (lk_valid_r && lk_ready && (pref_left_r != CNT_WIDTH'(0))) begin
          lk_nx_s.line   = lk_r.line + LINE_WIDTH'(1);
          lk_nx_s.beat   = lk_r.beat + BEAT_WIDTH'(1);
          lk_nx_s.last   = (pref_left_r == CNT_WIDTH'(1));
          pref_left_nx_s = pref_left_r - CNT_WIDTH'(1);
        end else if (lk_valid_r && lk_ready) begin
          state_nx_s       = IDLE;
          lk_valid_nx_s    = 1'b0;
          lk_nx_s.last     = 1'b0;
          lk_nx_s.prefetch = 1'b0;
        end else begin
          lk_valid_nx_s = lk_valid_r;
        end
      end
`endif
      default: begin
        state_nx_s    = IDLE;
        lk_valid_nx_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; ready/busy follow the next state so they are registered too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      lk_r        <= '0;
      lk_valid_r  <= 1'b0;
      dem_left_r  <= NLINES_WIDTH'(0);
      pref_left_r <= CNT_WIDTH'(0);
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      lk_r        <= lk_nx_s;
      lk_valid_r  <= lk_valid_nx_s;
      dem_left_r  <= dem_left_nx_s;
      pref_left_r <= pref_left_nx_s;
      err_r       <= err_nx_s;
      busy_r      <= (state_nx_s != IDLE);
      req_ready_r <= (state_nx_s == IDLE);
    end
  end

  assign req_ready   = req_ready_r;
  assign lk_valid    = lk_valid_r;
  assign lk_tag      = lk_r.line[LINE_WIDTH-1:SET_INDEX_WIDTH];
  assign lk_set      = lk_r.line[SET_INDEX_WIDTH-1:0];
  assign lk_offset   = lk_r.offset;
  assign lk_txn_id   = lk_r.txn_id;
  assign lk_prio     = lk_r.prio;
  assign lk_write    = lk_r.write;
  assign lk_beat     = lk_r.beat;
  assign lk_last     = lk_r.last;
  assign lk_prefetch = lk_r.prefetch;
  assign err_size    = err_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_llc_req_splitter.sv
// Scoreboard bench for llc_req_splitter: a line-level model queues expected lookups, a monitor checks them.
module tb_llc_req_splitter;
  import llm_params::*;

  localparam int PF_DEPTH = 4;
  localparam int MAX_SIZE = 256;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        req_valid, req_ready;
  logic [ADDR_WIDTH-1:0]       req_addr;
  logic [SIZE_WIDTH-1:0]       req_size;
  logic [CHI_TXN_ID_WIDTH-1:0] req_txn_id;
  logic [CHI_PRIO_WIDTH-1:0]   req_prio;
  logic                        req_write;
  logic                        lk_valid, lk_ready;
  logic [TAG_WIDTH-1:0]        lk_tag;
  logic [SET_INDEX_WIDTH-1:0]  lk_set;
  logic [OFFSET_WIDTH-1:0]     lk_offset;
  logic [CHI_TXN_ID_WIDTH-1:0] lk_txn_id;
  logic [CHI_PRIO_WIDTH-1:0]   lk_prio;
  logic                        lk_write;
  logic [BEAT_WIDTH-1:0]       lk_beat;
  logic                        lk_last, lk_prefetch, err_size, busy;

  always #5 clk = ~clk;

  llc_req_splitter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_txn_id(req_txn_id),
    .req_prio(req_prio), .req_write(req_write), .lk_valid(lk_valid),
    .lk_ready(lk_ready), .lk_tag(lk_tag), .lk_set(lk_set), .lk_offset(lk_offset),
    .lk_txn_id(lk_txn_id), .lk_prio(lk_prio), .lk_write(lk_write),
    .lk_beat(lk_beat), .lk_last(lk_last), .lk_prefetch(lk_prefetch),
    .err_size(err_size), .busy(busy)
  );

  typedef struct packed {
    logic [TAG_WIDTH-1:0]        tag;
    logic [SET_INDEX_WIDTH-1:0]  set;
    logic [OFFSET_WIDTH-1:0]     offset;
    logic [CHI_TXN_ID_WIDTH-1:0] txn;
    logic [CHI_PRIO_WIDTH-1:0]   prio;
    logic                        write;
    logic [BEAT_WIDTH-1:0]       beat;
    logic                        last;
    logic                        pf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;  // 0 random, 1 always ready, 2 stalled

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: enumerate the lines a request touches, then the prefetch lines.
  task automatic push_model(input logic [63:0] addr, input int size, input logic [15:0] txn,
                            input logic [2:0] prio, input logic wr, output bit legal);
    logic [63:0]           first_line, end_line, nl;
    logic [LINE_WIDTH-1:0] ln;
    int                    n_pf, total;
    exp_t                  e;
    legal = (size >= 1) && (size <= MAX_SIZE);
    if (legal) begin
      first_line = addr >> OFFSET_WIDTH;
      end_line   = (addr + 64'(size) - 64'd1) >> OFFSET_WIDTH;
      // Count within the line-address space so a request crossing 2^64 stays small.
      nl = (end_line - first_line + 64'd1) & ((64'd1 << LINE_WIDTH) - 64'd1);
`ifdef LLC_SPLIT_PREFETCH_EN
      n_pf = wr ? 0 : PF_DEPTH;
`else
      n_pf = 0;
`endif
      total = int'(nl) + n_pf;
      for (int i = 0; i < total; i++) begin
        ln       = LINE_WIDTH'(first_line + 64'(i));
        e.tag    = ln[LINE_WIDTH-1:SET_INDEX_WIDTH];
        e.set    = ln[SET_INDEX_WIDTH-1:0];
        e.offset = (i == 0) ? addr[OFFSET_WIDTH-1:0] : '0;
        e.txn    = txn;
        e.pf     = (i >= int'(nl));
        e.prio   = e.pf ? 3'd0 : prio;
        e.write  = wr;
        e.beat   = 3'(i);
        e.last   = (i == total - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: checks every handshake against the scoreboard and stability while stalled.
  initial begin
    logic        prev_stall;
    exp_t        prev_out, cur, e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      cur = '{lk_tag, lk_set, lk_offset, lk_txn_id, lk_prio, lk_write, lk_beat, lk_last, lk_prefetch};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(lk_valid), 64'd1);
          chk("stall_hold", 64'(cur == prev_out), 64'd1);
        end
        if (lk_valid && lk_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_lookup actual beat=%0d set=0x%0h expected none", lk_beat, lk_set);
          end else begin
            e = sb_q.pop_front();
            chk("lk_tag", 64'(lk_tag), 64'(e.tag));
            chk("lk_set", 64'(lk_set), 64'(e.set));
            chk("lk_offset", 64'(lk_offset), 64'(e.offset));
            chk("lk_txn_id", 64'(lk_txn_id), 64'(e.txn));
            chk("lk_prio", 64'(lk_prio), 64'(e.prio));
            chk("lk_write", 64'(lk_write), 64'(e.write));
            chk("lk_beat", 64'(lk_beat), 64'(e.beat));
            chk("lk_last", 64'(lk_last), 64'(e.last));
            chk("lk_prefetch", 64'(lk_prefetch), 64'(e.pf));
          end
        end
        prev_stall = lk_valid && !lk_ready;
        prev_out   = cur;
      end
    end
  end

  // Downstream ready generator.
  initial begin
    lk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       lk_ready = (($urandom % 4) != 0);
        1:       lk_ready = 1'b1;
        default: lk_ready = 1'b0;
      endcase
    end
  end

  // Called and returns at posedge+1.
  task automatic send(input logic [63:0] addr, input int size, input logic wr,
                      input logic [2:0] prio, input logic [15:0] txn);
    int n;
    bit legal;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout actual=0 expected=1");
    end else begin
      req_valid = 1'b1; req_addr = addr; req_size = SIZE_WIDTH'(size);
      req_write = wr; req_prio = prio; req_txn_id = txn;
      push_model(addr, size, txn, prio, wr, legal);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("err_size", 64'(err_size), 64'(!legal));
      chk("lk_valid_latency", 64'(lk_valid), 64'(legal));
      if (!legal) chk("ready_after_err", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int          n, r, sz;
    logic [63:0] a;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
    req_txn_id = '0; req_prio = '0; req_write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_lk_valid", 64'(lk_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err_size", 64'(err_size), 64'd0);
    chk("rst_lk_last", 64'(lk_last), 64'd0);
    chk("rst_lk_prefetch", 64'(lk_prefetch), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    rdy_mode = 1;
    send(64'h1000, 64, 1'b0, 3'd5, 16'h0A01);
    drain();
    rdy_mode = 2;
    send(64'h103C, 8, 1'b0, 3'd2, 16'h0A02);
    repeat (3) @(posedge clk);
    #1 rdy_mode = 1;
    drain();
    send(64'h4000, 0, 1'b0, 3'd1, 16'h0A03);
    send(64'h4000, 257, 1'b1, 3'd1, 16'h0A04);
    send(64'hFFFF_FFFF_FFFF_FFC0, 128, 1'b0, 3'd7, 16'h0A05);
    send(64'h2000, 256, 1'b0, 3'd6, 16'h0A06);
    send(64'h2000, 256, 1'b1, 3'd6, 16'h0A07);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom % 4;
      if (r == 0)      a = {$urandom, $urandom};
      else if (r == 1) a = 64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom % 256);
      else             a = 64'($urandom % 32'h10000);
      if (($urandom % 10) == 0) sz = (($urandom % 2) == 0) ? 0 : 257 + int'($urandom % 255);
      else                      sz = 1 + int'($urandom % MAX_SIZE);
      send(a, sz, 1'($urandom), 3'($urandom), 16'($urandom));
    end
    drain();

    // Reset in the middle of a 5-line request.
    rdy_mode = 1;
    send(64'h1010, 256, 1'b1, 3'd3, 16'h0B01);
    n = 0;
    while (!(lk_valid && lk_beat == 3'd2) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("reached_beat2", 64'(lk_valid && lk_beat == 3'd2), 64'd1);
    rst = 1'b1; rdy_mode = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_lk_valid", 64'(lk_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rdy_mode = 0;
    send(64'h3F80, 100, 1'b0, 3'd4, 16'h0B02);
    drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
